kanagawa_sim_valid_stall_to_mailbox: RTL

//  Simulation sink: downstream counterpart of the mailbox-to-valid/stall driver. Accepts items on a

---
 rtl/kanagawa_sim_sink_pkg.sv | 28 ++
 rtl/kanagawa_sim_skid_fifo.sv | 81 ++++++++
 rtl/kanagawa_sim_valid_stall_to_mailbox.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/kanagawa_sim_sink_pkg.sv
// Shared types and sizing helpers for the valid/stall-to-mailbox simulation sink.
package kanagawa_sim_sink_pkg;

    // Back-pressure injection policy applied on top of the FIFO threshold stall.
    typedef enum logic [0:0] {
        STALL_NONE   = 1'b0,
        STALL_RANDOM = 1'b1
    } stall_policy_e;

    // An all-zero LFSR would lock up, so a zero seed selects this value instead.
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Skid slots needed so that every in-flight item fits once stall is raised.
    function automatic int unsigned fifo_depth(input int unsigned lat, input int unsigned extra);
        return lat + 2 + extra;
    endfunction

    // Width of a counter that must represent 0..fifo_depth inclusive.
    function automatic int unsigned occ_width(input int unsigned lat, input int unsigned extra);
        return $clog2(fifo_depth(lat, extra) + 1);
    endfunction

    // Pointer width for a circular buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return (entries <= 2) ? 1 : $clog2(entries);
    endfunction

endpackage

// File: rtl/kanagawa_sim_skid_fifo.sv
// Skid FIFO for the valid/stall sink. Writes are unconditional (upstream does
// not wait for ready); an item arriving while full with no drain is dropped and
// the sticky overflow flag is raised. When empty and the consumer has room the
// incoming item is forwarded in the same cycle.
module kanagawa_sim_skid_fifo
    import kanagawa_sim_sink_pkg::*;
#(
    parameter int unsigned WIDTH               = 8,
    parameter int unsigned STALL_VALID_LATENCY = 0,
    parameter int unsigned EXTRA_DEPTH         = 0,
    localparam int unsigned FIFO_DEPTH = fifo_depth(STALL_VALID_LATENCY, EXTRA_DEPTH),
    localparam int unsigned OCC_W      = occ_width(STALL_VALID_LATENCY, EXTRA_DEPTH),
    localparam int unsigned PTR_W      = ptr_width(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             room,
    output logic             drain,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] count,
    output logic             above_threshold,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             drop;

    assign empty = (count == '0);
    assign full  = (count == OCC_W'(FIFO_DEPTH));

    // A drain frees a slot in the same cycle, so a write into a full FIFO is
    // only lost when nothing leaves.
    assign drain = room & (~empty | wr_en);
    assign push  = wr_en & (~full | drain);
    assign drop  = wr_en & full & ~drain;

    // With an empty FIFO rd_ptr == wr_ptr, so the bypass item is both written
    // and consumed and the pointers stay aligned.
    assign head_data       = empty ? wr_data : mem[rd_ptr];
    assign above_threshold = (count >= OCC_W'(1 + EXTRA_DEPTH));

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array: no reset, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (drain) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + OCC_W'(push) - OCC_W'(drain);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/kanagawa_sim_valid_stall_to_mailbox.sv
// Valid/stall sink that lands items in a readable mailbox.
// Upstream honours stall_out only STALL_VALID_LATENCY cycles late; the skid FIFO
// absorbs the items still in flight and a drain stage moves one item per cycle
// into the mailbox. The mailbox is read through mb_get (pop head when mb_valid),
// mb_clear (empty it) and mb_num (current item count).
// DEPTH=0 means "unlimited": the mailbox is sized to UNLIMITED_CAP entries.
// With CLEAR_ON_RESET=0 the mailbox ignores reset and must be emptied once with
// mb_clear before first use.
// Optional checks: define KANAGAWA_SIM_SINK_PROTOCOL_CHECK_EN to flag X/Z on the
// input interface, stop on overflow and report item totals at end of simulation.
module kanagawa_sim_valid_stall_to_mailbox
    import kanagawa_sim_sink_pkg::*;
#(
    parameter int unsigned   WIDTH               = 8,
    parameter int unsigned   DEPTH               = 0,
    parameter int unsigned   STALL_VALID_LATENCY = 0,
    parameter int unsigned   EXTRA_DEPTH         = 0,
    parameter bit            CLEAR_ON_RESET      = 1'b1,
    parameter stall_policy_e STALL_POLICY        = STALL_NONE,
    parameter int unsigned   STALLER_SEED        = 0,
    parameter int unsigned   UNLIMITED_CAP       = 64,
    localparam int unsigned FIFO_DEPTH = fifo_depth(STALL_VALID_LATENCY, EXTRA_DEPTH),
    localparam int unsigned OCC_W      = occ_width(STALL_VALID_LATENCY, EXTRA_DEPTH),
    localparam int unsigned MB_CAP     = (DEPTH == 0) ? UNLIMITED_CAP : DEPTH,
    localparam int unsigned MB_PTR_W   = ptr_width(MB_CAP),
    localparam int unsigned MB_CNT_W   = $clog2(MB_CAP + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [WIDTH-1:0]    data_in,
    output logic                stall_out,
    output logic [OCC_W-1:0]    occupancy_out,
    output logic                overflow_out,
    input  logic                mb_get,
    input  logic                mb_clear,
    output logic                mb_valid,
    output logic [WIDTH-1:0]    mb_data,
    output logic [MB_CNT_W-1:0] mb_num
);

    localparam logic [15:0] SEED_INIT = (STALLER_SEED == 0) ? LFSR_DEFAULT_SEED
                                                            : 16'(STALLER_SEED);

    logic [1:0]  rst_sync;
    logic        rst_int_n;
    logic        mb_rst_n;
    logic        wr_en;
    logic        mb_room;
    logic        mb_pop;
    logic        fifo_drain;
    logic [WIDTH-1:0] fifo_head;
    logic        above_threshold;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        policy_stall;

    logic [WIDTH-1:0]    mb_mem [MB_CAP];
    logic [MB_PTR_W-1:0] mb_wr_ptr;
    logic [MB_PTR_W-1:0] mb_rd_ptr;
    logic [MB_CNT_W-1:0] mb_count;

    // Reset asserts asynchronously and releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];
    assign mb_rst_n  = CLEAR_ON_RESET ? rst_int_n : 1'b1;

    // Items presented while reset is active are ignored.
    assign wr_en = valid_in & rst_int_n;

    // Drain is gated only by mailbox space, never by the policy stall.
    assign mb_room = rst_int_n & ~mb_clear & (mb_count < MB_CNT_W'(MB_CAP));
    assign mb_pop  = mb_get & ~mb_clear & (mb_count != '0);

    kanagawa_sim_skid_fifo #(
        .WIDTH               (WIDTH),
        .STALL_VALID_LATENCY (STALL_VALID_LATENCY),
        .EXTRA_DEPTH         (EXTRA_DEPTH)
    ) u_skid_fifo (
        .clk             (clk),
        .rst_n           (rst_int_n),
        .wr_en           (wr_en),
        .wr_data         (data_in),
        .room            (mb_room),
        .drain           (fifo_drain),
        .head_data       (fifo_head),
        .count           (occupancy_out),
        .above_threshold (above_threshold),
        .overflow        (overflow_out)
    );

    // Galois-free Fibonacci LFSR (taps 16,14,13,11); with the random policy it
    // requests a stall cycle roughly one time in four.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lfsr         <= SEED_INIT;
            policy_stall <= 1'b0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr_fb};
            policy_stall <= (STALL_POLICY == STALL_RANDOM) && (lfsr[1:0] == 2'b00);
        end
    end

    // Stall is built from registered state only; it reads 1 throughout reset.
    assign stall_out = ~rst_int_n | policy_stall | above_threshold;

    // Mailbox storage: written by the drain stage, contents qualified by mb_count.
    always_ff @(posedge clk) begin
        if (fifo_drain) begin
            mb_mem[mb_wr_ptr] <= fifo_head;
        end
    end

    // Mailbox pointers and count; mb_clear takes priority over drain and get.
    always_ff @(posedge clk or negedge mb_rst_n) begin
        if (!mb_rst_n) begin
            mb_wr_ptr <= '0;
            mb_rd_ptr <= '0;
            mb_count  <= '0;
        end else if (mb_clear) begin
            mb_wr_ptr <= '0;
            mb_rd_ptr <= '0;
            mb_count  <= '0;
        end else begin
            if (fifo_drain) begin
                mb_wr_ptr <= (mb_wr_ptr == MB_PTR_W'(MB_CAP - 1)) ? '0 : mb_wr_ptr + 1'b1;
            end
            if (mb_pop) begin
                mb_rd_ptr <= (mb_rd_ptr == MB_PTR_W'(MB_CAP - 1)) ? '0 : mb_rd_ptr + 1'b1;
            end
            mb_count <= mb_count + MB_CNT_W'(fifo_drain) - MB_CNT_W'(mb_pop);
        end
    end

    assign mb_valid = (mb_count != '0);
    assign mb_data  = mb_mem[mb_rd_ptr];
    assign mb_num   = mb_count;

`ifdef KANAGAWA_SIM_SINK_PROTOCOL_CHECK_EN
    int unsigned n_accepted;
    int unsigned n_drained;
    logic        fifo_drop;

    assign fifo_drop = wr_en & (occupancy_out == OCC_W'(FIFO_DEPTH)) & ~fifo_drain;

    // Interface sanity checks and item accounting while out of reset.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            n_accepted <= 0;
            n_drained  <= 0;
        end else begin
            if ($isunknown(valid_in)) begin
                $error("kanagawa_sim_valid_stall_to_mailbox: valid_in is X/Z");
            end else if (valid_in && $isunknown(data_in)) begin
                $error("kanagawa_sim_valid_stall_to_mailbox: data_in is X/Z with valid_in=1");
            end
            if (fifo_drop) begin
                $fatal(1, "kanagawa_sim_valid_stall_to_mailbox: item dropped, skid FIFO overflow");
            end
            if (wr_en && !fifo_drop) begin
                n_accepted <= n_accepted + 1;
            end
            if (fifo_drain) begin
                n_drained <= n_drained + 1;
            end
        end
    end

    final begin
        $display("kanagawa_sim_valid_stall_to_mailbox: %0d items accepted, %0d drained",
                 n_accepted, n_drained);
    end
`endif

endmodule
